native_mem_arbiter: RTL and testbench

- N-master to 1-slave arbiter on the PicoRV32 native memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Lets the CPU, a program loader and debug/DMA masters share one memory controller (e.g. bram_controller).
- Replaces ad-hoc 2:1 muxing of memory request lines with a parametrised, registered-grant arbiter.
- Supports fixed or round-robin priority, plus an optional slave timeout that completes a stalled access with an error.

---
 rtl/native_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_native_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : native_mem_arbiter
// Brief   : N:1 registered-grant arbiter for the PicoRV32 native memory bus
// Revision: 1.0
// ============================================================================
module native_mem_arbiter #(
    parameter int                    NUM_MASTERS    = 2,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ARB_MODE       = 0,
    parameter int                    TIMEOUT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEAD_BEEF),
    localparam int                   c_gw           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int                   c_sw           = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_MASTERS-1:0]            m_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*c_sw-1:0]       m_wstrb,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic                              s_valid,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [c_sw-1:0]                   s_wstrb,
    input  logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [c_gw-1:0]                   grant_idx,
    output logic                              busy,
    output logic                              timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int              c_cw       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_to_last  = c_cw'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_gw-1:0] c_last_idx = c_gw'(NUM_MASTERS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_gw-1:0]   r_grant;
    logic [c_gw-1:0]   w_grant_nxt;
    logic [c_gw-1:0]   r_rr_ptr;
    logic [c_gw-1:0]   w_rr_ptr_nxt;
    logic [c_gw-1:0]   w_winner;
    logic [c_cw-1:0]   r_wait_cnt;
    logic [c_cw-1:0]   w_wait_cnt_nxt;

    logic                  w_sel_valid;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [c_sw-1:0]       w_sel_wstrb;

    logic w_in_grant;
    logic w_complete;
    logic w_timeout;
    logic w_cancel;
    logic w_done;

    // First requester found scanning upward from the start index, wrapping.
    function automatic logic [c_gw-1:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [c_gw-1:0]        start);
        logic [c_gw-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && req[idx]) begin
                pick  = c_gw'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_winner = f_pick(m_valid, (ARB_MODE == 1) ? r_rr_ptr : '0);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant == c_gw'(i)) begin
                w_sel_valid = m_valid[i];
                w_sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_wstrb = m_wstrb[i*c_sw +: c_sw];
            end
        end
    end

    assign w_in_grant = (r_state == ST_GRANT);
    assign w_cancel   = w_in_grant && !w_sel_valid;
    assign w_complete = w_in_grant && w_sel_valid && s_ready;
    // A late s_ready in the final wait cycle takes precedence over the abort.
    assign w_timeout  = (TIMEOUT_CYCLES > 0) && w_in_grant && w_sel_valid && !s_ready
                        && (r_wait_cnt == c_to_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|m_valid) begin
                    w_state_nxt    = ST_GRANT;
                    w_grant_nxt    = w_winner;
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (w_complete || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    if (ARB_MODE == 1) begin
                        w_rr_ptr_nxt = (r_grant == c_last_idx) ? '0 : r_grant + c_gw'(1);
                    end
                end else if (w_cancel) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_cw'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Gating with reset_n drops the request in the very cycle reset is applied.
    assign w_done      = reset_n && (w_complete || w_timeout);
    assign s_valid     = reset_n && w_in_grant && w_sel_valid && !w_timeout;
    assign s_addr      = w_sel_addr;
    assign s_wdata     = w_sel_wdata;
    assign s_wstrb     = w_sel_wstrb;
    assign grant_idx   = r_grant;
    assign busy        = w_in_grant;
    assign timeout_err = reset_n && w_timeout;

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
            assign m_ready[i] = w_done && (r_grant == c_gw'(i));
            assign m_rdata[i*DATA_WIDTH +: DATA_WIDTH] =
                m_ready[i] ? (w_timeout ? ERR_DATA : s_rdata) : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_native_mem_arbiter.sv
`default_nettype none
// Scoreboard bench: randomized round-robin DUT with timeout plus a fixed-priority DUT.
module tb_native_mem_arbiter;

    localparam int          N          = 3;
    localparam int          TO         = 8;
    localparam logic [31:0] ERR        = 32'hDEAD_BEEF;
    localparam logic [31:0] STALL_BASE = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // round-robin DUT
    logic [N-1:0]    m_valid;
    logic [N*32-1:0] m_addr, m_wdata, m_rdata;
    logic [N*4-1:0]  m_wstrb;
    logic [N-1:0]    m_ready;
    logic            s_valid, s_ready;
    logic [31:0]     s_addr, s_wdata, s_rdata;
    logic [3:0]      s_wstrb;
    logic [1:0]      grant_idx;
    logic            busy, timeout_err;

    // fixed-priority DUT
    logic [1:0]  f_m_valid, f_m_ready;
    logic [63:0] f_m_addr, f_m_wdata, f_m_rdata;
    logic [7:0]  f_m_wstrb;
    logic        f_s_valid, f_s_ready;
    logic [31:0] f_s_addr, f_s_wdata, f_s_rdata;
    logic [3:0]  f_s_wstrb;
    logic [0:0]  f_grant_idx;
    logic        f_busy, f_timeout_err;

    native_mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1),
                         .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut_rr (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .s_valid(s_valid),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
        .s_rdata(s_rdata), .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err));

    native_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0),
                         .TIMEOUT_CYCLES(0), .ERR_DATA(ERR)) dut_fp (
        .clk(clk), .reset_n(reset_n), .m_valid(f_m_valid), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
        .m_wstrb(f_m_wstrb), .m_ready(f_m_ready), .m_rdata(f_m_rdata), .s_valid(f_s_valid),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_ready(f_s_ready),
        .s_rdata(f_s_rdata), .grant_idx(f_grant_idx), .busy(f_busy), .timeout_err(f_timeout_err));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        to;
    } exp_t;
    exp_t sq[N][$];

    typedef struct {
        int          idx;
        logic [31:0] addr;
    } fexp_t;
    fexp_t fq[$];

    logic [31:0] shadow [0:1023];
    logic [31:0] mem    [0:1023];
    logic        slv_dead;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // ---------------- BRAM-like slave with random wait states ----------------
    initial begin
        logic slv_busy;
        int   slv_wait;
        for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
        s_ready  = 1'b0;
        s_rdata  = 32'h0;
        slv_busy = 1'b0;
        slv_wait = 0;
        forever begin
            @(posedge clk); #2;
            if (!s_valid) begin
                slv_busy = 1'b0;
                s_ready  = 1'b0;
                s_rdata  = 32'h0;
            end else begin
                if (!slv_busy) begin
                    slv_busy = 1'b1;
                    slv_wait = $urandom_range(0, 2);
                end else if (slv_wait > 0) begin
                    slv_wait--;
                end
                s_ready = (slv_wait == 0) && (s_addr < STALL_BASE) && !slv_dead;
                s_rdata = mem[s_addr[11:2]];
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_addr[11:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
                slv_busy = 1'b0;
            end
        end
    end

    // ---------------- one-wait slave for the fixed-priority DUT ----------------
    initial begin
        int fcnt;
        fcnt      = 0;
        f_s_ready = 1'b0;
        f_s_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (f_s_valid) fcnt++;
            else fcnt = 0;
            f_s_ready = (fcnt == 2);
            f_s_rdata = f_s_addr ^ 32'hA5A5_0000;
        end
    end

    // ---------------- round-robin monitor / scoreboard ----------------
    initial begin
        int          ptr, gcyc, exp_g;
        logic        prev_busy, prev_rstn, prev_done, exp_to;
        logic [N-1:0] prev_valid;
        exp_t        e;
        ptr = 0; gcyc = 0; exp_g = 0;
        prev_busy = 1'b0; prev_rstn = 1'b0; prev_done = 1'b0; prev_valid = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int i = 0; i < N; i++) sq[i].delete();
                ptr  = 0;
                gcyc = 0;
            end else begin
                if (prev_rstn && !prev_busy && prev_valid != '0) begin
                    exp_g = pick(prev_valid, ptr);
                    chk("arb_busy", 32'(busy), 32'd1);
                    chk("arb_grant", 32'(grant_idx), 32'(exp_g));
                end
                if (prev_rstn && prev_done) chk("idle_gap", 32'(busy), 32'd0);
                gcyc   = busy ? gcyc + 1 : 0;
                exp_to = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (m_ready[i]) begin
                        chk("ready_busy", 32'(busy), 32'd1);
                        chk("ready_idx", 32'(i), 32'(exp_g));
                        if (sq[i].size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_ready: master %0d got m_ready, none expected", i);
                        end else begin
                            e = sq[i].pop_front();
                            if (e.rd) chk("rdata", m_rdata[i*32 +: 32], e.data);
                            if (e.to) begin
                                exp_to = 1'b1;
                                chk("timeout_cycle", 32'(gcyc), 32'(TO));
                            end
                        end
                        ptr = (i + 1) % N;
                    end else begin
                        chk("rdata_zero", m_rdata[i*32 +: 32], 32'h0);
                    end
                end
                chk("timeout_err", 32'(timeout_err), 32'(exp_to));
                if (busy && m_valid[exp_g]) begin
                    chk("s_valid", 32'(s_valid), 32'(!exp_to));
                    chk("s_addr", s_addr, m_addr[exp_g*32 +: 32]);
                    chk("s_wdata", s_wdata, m_wdata[exp_g*32 +: 32]);
                    chk("s_wstrb", 32'(s_wstrb), 32'(m_wstrb[exp_g*4 +: 4]));
                end
                if (busy && !m_valid[exp_g]) chk("cancel_svalid", 32'(s_valid), 32'd0);
            end
            prev_done  = (m_ready != '0) || (busy && !m_valid[exp_g]);
            prev_busy  = busy;
            prev_valid = m_valid;
            prev_rstn  = reset_n;
        end
    end

    // ---------------- fixed-priority monitor ----------------
    initial begin
        fexp_t fe;
        forever begin
            @(negedge clk);
            if (reset_n && f_m_ready != 2'b00) begin
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fp_unexpected_ready: m_ready=%b", f_m_ready);
                end else begin
                    fe = fq.pop_front();
                    chk("fp_grant", 32'(f_grant_idx), 32'(fe.idx));
                    chk("fp_ready", 32'(f_m_ready), 32'(1 << fe.idx));
                    chk("fp_addr", f_s_addr, fe.addr);
                    chk("fp_rdata", f_m_rdata[fe.idx*32 +: 32], fe.addr ^ 32'hA5A5_0000);
                end
            end
        end
    end

    // ---------------- master-side transaction ----------------
    task automatic do_txn(input int i, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
        exp_t e;
        logic got;
        @(posedge clk); #1;
        e.rd   = (strb == 4'b0);
        e.to   = (addr >= STALL_BASE) || slv_dead;
        e.data = e.to ? ERR : shadow[addr[11:2]];
        if (!e.rd && !e.to)
            for (int b = 0; b < 4; b++)
                if (strb[b]) shadow[addr[11:2]][b*8 +: 8] = data[b*8 +: 8];
        sq[i].push_back(e);
        m_addr[i*32 +: 32]  = addr;
        m_wdata[i*32 +: 32] = data;
        m_wstrb[i*4 +: 4]   = strb;
        m_valid[i]          = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (m_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL txn_wait: master %0d addr %h never got m_ready", i, addr);
        end
        @(posedge clk); #1;
        m_valid[i] = 1'b0;
    endtask

    task automatic rand_master(input int i, input int n);
        int          r;
        logic [31:0] addr;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r    = $urandom_range(0, 9);
            addr = 32'(i * 256 + $urandom_range(0, 7) * 4);
            if (r < 4)      do_txn(i, addr, $urandom, 4'($urandom_range(1, 15)));
            else if (r < 9) do_txn(i, addr, 32'h0, 4'b0);
            else            do_txn(i, STALL_BASE + addr, 32'h0, 4'b0);
        end
    endtask

    task automatic wait_busy(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: busy never rose", name);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] pat, pending, drop;
        fexp_t      fe;
        for (int a = 0; a < 1024; a++) shadow[a] = 32'h0;
        slv_dead  = 1'b0;
        reset_n   = 1'b0;
        m_valid   = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        f_m_valid = '0; f_m_addr = '0; f_m_wdata = '0; f_m_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_svalid", 32'(s_valid), 32'd0);
        chk("reset_mready", 32'(m_ready), 32'd0);
        chk("reset_grant", 32'(grant_idx), 32'd0);
        chk("reset_terr", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // fixed priority: simultaneous and random request patterns
        for (int k = 0; k < 12; k++) begin
            pat = (k == 0) ? 2'b11 : 2'($urandom_range(1, 3));
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                f_m_addr[i*32 +: 32] = 32'(i * 256 + k * 4);
                if (pat[i]) begin
                    fe.idx  = i;
                    fe.addr = 32'(i * 256 + k * 4);
                    fq.push_back(fe);
                end
            end
            f_m_valid = pat;
            pending   = pat;
            for (int c = 0; c < 40 && pending != 2'b00; c++) begin
                @(negedge clk);
                if (f_m_ready != 2'b00) begin
                    drop = f_m_ready;
                    @(posedge clk); #1;
                    f_m_valid = f_m_valid & ~drop;
                    pending   = pending & ~drop;
                end
            end
            if (pending != 2'b00) begin
                total++; bad++;
                $display("FAIL fp_wait: pending=%b never served", pending);
                f_m_valid = 2'b00;
            end
        end

        // write by master 1, read back by master 0
        do_txn(1, 32'h10, 32'h0000_0013, 4'b1111);
        do_txn(0, 32'h10, 32'h0, 4'b0);

        // slave never ready: timeout abort
        slv_dead = 1'b1;
        do_txn(0, 32'h40, 32'h0, 4'b0);
        slv_dead = 1'b0;

        fork
            rand_master(0, 30);
            rand_master(1, 30);
            rand_master(2, 30);
        join

        // cancel must leave the rr pointer alone (master 0 completion sets it to 1)
        do_txn(0, 32'h4, 32'h0, 4'b0);
        @(posedge clk); #1;
        m_addr[2*32 +: 32] = STALL_BASE;
        m_wstrb[2*4 +: 4]  = 4'b0;
        m_valid[2]         = 1'b1;
        wait_busy("cancel_grant");
        @(posedge clk); #1;
        m_valid[2] = 1'b0;
        @(negedge clk);
        chk("cancel_s_valid", 32'(s_valid), 32'd0);
        chk("cancel_m_ready", 32'(m_ready), 32'd0);
        @(negedge clk);
        chk("cancel_idle", 32'(busy), 32'd0);
        fork
            do_txn(0, 32'h8, 32'h0, 4'b0);
            do_txn(1, 32'h108, 32'h0, 4'b0);
            do_txn(2, 32'h208, 32'h0, 4'b0);
        join

        // reset in the middle of a stalled grant
        @(posedge clk); #1;
        m_addr[2*32 +: 32] = STALL_BASE + 32'h40;
        m_valid[2]         = 1'b1;
        wait_busy("reset_grant");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_cycle_svalid", 32'(s_valid), 32'd0);
        chk("rst_cycle_mready", 32'(m_ready), 32'd0);
        @(posedge clk); #1;
        reset_n    = 1'b1;
        m_valid[2] = 1'b0;
        @(negedge clk);
        chk("post_rst_svalid", 32'(s_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_grant", 32'(grant_idx), 32'd0);
        chk("post_rst_mready", 32'(m_ready), 32'd0);
        do_txn(2, 32'h20C, 32'hCAFE_F00D, 4'b1111);
        do_txn(2, 32'h20C, 32'h0, 4'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
